// File: rtl/intr_ctrl.sv
// intr_ctrl: prioritised interrupt controller for NUM_SRC sources.
// Sources are latched into PEND, gated by MASK and the global enable,
// and the lowest-index active source wins.  The winner is presented to
// the CPU through the intr/int_ack pair, and the serviced vector is
// readable through the memory-mapped VEC register.
// Build option: define INTC_EDGE_EN for edge-detected sticky pending bits.
// Without it, the controller runs in level mode and PEND follows src_irq.
//
// CPU handshake: intr is a registered request.  Once raised, it is held
// until int_ack is seen high.  The vector is captured on that same cycle,
// and intr drops on the next edge.  The controller then waits for int_ack
// to fall before it can raise another request.  An int_ack that does not
// answer an outstanding intr is ignored.
module intr_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int DW      = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               io_cs,
  input  logic               io_wr,
  input  logic               io_rd,
  input  logic [1:0]         io_addr,
  input  logic [DW-1:0]      io_din,
  output logic [DW-1:0]      io_dout,
  output logic               intr,
  input  logic               int_ack,
  output logic               ie,
  output logic [1:0]         dbg_state
);

  localparam int VEC_W = $clog2(NUM_SRC + 1);
  localparam logic [VEC_W-1:0] VEC_NONE = VEC_W'(NUM_SRC);

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_VEC  = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pend;
  logic [VEC_W-1:0]   vec_q;
  logic [NUM_SRC-1:0] act;
  logic [NUM_SRC-1:0] win_oh;
  logic [VEC_W-1:0]   winner;
  logic               wr_en;
  logic               rd_en;
  logic               ack_take;
  logic [DW-1:0]      pend_word;
  logic [DW-1:0]      mask_word;
  logic [DW-1:0]      vec_word;
  logic               unused_din;

  assign wr_en     = io_cs & io_wr;
  assign rd_en     = io_cs & io_rd;
  assign ack_take  = (state == S_REQ) & int_ack;
  assign dbg_state = state;
  // Only the low NUM_SRC bits of a write carry meaning.
  assign unused_din = ^io_din;

`ifdef INTC_EDGE_EN
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ack_clr;

  assign w1c     = (wr_en && io_addr == A_PEND) ? io_din[NUM_SRC-1:0] : '0;
  assign ack_clr = ack_take ? win_oh : '0;
  assign pend    = pend_q;

  // Sticky pending bits.  A new rising edge overrides any clear in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      src_q  <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= src_irq;
      pend_q <= (pend_q & ~w1c & ~ack_clr) | (src_irq & ~src_q);
    end
  end
`else
  // Level mode: sources are expected to hold their request until serviced.
  assign pend = src_irq;
`endif

  assign act = pend & mask;

  // Fixed priority: the lowest active index wins, and an empty set gives the spurious vector.
  always_comb begin
    winner = VEC_NONE;
    win_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (act[i]) begin
        winner    = VEC_W'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // Zero-extended register views for the read mux.
  always_comb begin
    pend_word                = '0;
    pend_word[NUM_SRC-1:0]   = pend;
    mask_word                = '0;
    mask_word[NUM_SRC-1:0]   = mask;
    vec_word                 = '0;
    vec_word[VEC_W-1:0]      = vec_q;
  end

  // MASK and CTRL write-side registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      mask <= '0;
      ie   <= 1'b0;
    end else if (wr_en) begin
      if (io_addr == A_MASK) mask <= io_din[NUM_SRC-1:0];
      if (io_addr == A_CTRL) ie   <= io_din[0];
    end
  end

  // Registered read data.  It holds the requested word for one cycle and is zero otherwise.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      io_dout <= '0;
    end else if (rd_en) begin
      case (io_addr)
        A_PEND:  io_dout <= pend_word;
        A_MASK:  io_dout <= mask_word;
        A_VEC:   io_dout <= vec_word;
        A_CTRL:  io_dout <= {{(DW-1){1'b0}}, ie};
        default: io_dout <= '0;
      endcase
    end else begin
      io_dout <= '0;
    end
  end

  // Request/acknowledge FSM.  The vector is chosen at acknowledge time, not at request time.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= S_IDLE;
      intr  <= 1'b0;
      vec_q <= VEC_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (ie && |act) begin
            state <= S_REQ;
            intr  <= 1'b1;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            vec_q <= winner;
            intr  <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!int_ack) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed test bench for intr_ctrl.
// Expected read data and intr values are queued when stimulus is issued.
// A monitor compares them against the design one edge later.
// Both the level build and the INTC_EDGE_EN build are covered.
module tb_intr_ctrl;

  localparam int NUM_SRC = 8;
  localparam int DW      = 32;

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_VEC  = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic [NUM_SRC-1:0] src_irq;
  logic               io_cs;
  logic               io_wr;
  logic               io_rd;
  logic [1:0]         io_addr;
  logic [DW-1:0]      io_din;
  logic [DW-1:0]      io_dout;
  logic               intr;
  logic               int_ack;
  logic               ie;
  logic [1:0]         dbg_state;

  intr_ctrl #(.NUM_SRC(NUM_SRC), .DW(DW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .src_irq   (src_irq),
    .io_cs     (io_cs),
    .io_wr     (io_wr),
    .io_rd     (io_rd),
    .io_addr   (io_addr),
    .io_din    (io_din),
    .io_dout   (io_dout),
    .intr      (intr),
    .int_ack   (int_ack),
    .ie        (ie),
    .dbg_state (dbg_state)
  );

  // ---------------- clock/reset ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int            pass_cnt  = 0;
  int            total_cnt = 0;
  logic [DW-1:0] exp_q[$];
  string         name_q[$];
  logic          intr_q[$];
  string         iname_q[$];
  logic          chk_intr = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic          was_rd;
    logic          take_i;
    logic [DW-1:0] e;
    logic          ei;
    string         n;
    forever begin
      @(posedge sys_clk);
      was_rd = io_cs & io_rd;
      take_i = chk_intr;
      #1;
      if (was_rd) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL rd_unexpected: got 0x%0h expected no read response", io_dout);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check(n, io_dout, e);
        end
      end else begin
        check("dout_idle", io_dout, '0);
      end
      if (take_i) begin
        if (intr_q.size() == 0) begin
          total_cnt++;
          $display("FAIL intr_unexpected: got %0b expected no sample", intr);
        end else begin
          ei = intr_q.pop_front();
          n  = iname_q.pop_front();
          check(n, {31'b0, intr}, {31'b0, ei});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge sys_clk);
    chk_intr = 1'b0;
  endtask

  task automatic arm_intr(input logic v, input string n);
    intr_q.push_back(v);
    iname_q.push_back(n);
    chk_intr = 1'b1;
  endtask

  task automatic io_write(input logic [1:0] a, input logic [DW-1:0] d);
    io_cs = 1'b1; io_wr = 1'b1; io_addr = a; io_din = d;
    tick();
    io_cs = 1'b0; io_wr = 1'b0; io_din = '0;
  endtask

  task automatic io_read(input logic [1:0] a, input logic [DW-1:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    io_cs = 1'b1; io_rd = 1'b1; io_addr = a;
    tick();
    io_cs = 1'b0; io_rd = 1'b0;
  endtask

  // Assert sources.  When this returns, intr has been checked against exp.
  task automatic raise_src(input logic [NUM_SRC-1:0] bits, input logic exp, input string n);
`ifdef INTC_EDGE_EN
    src_irq = src_irq | bits;
    tick();
    src_irq = src_irq & ~bits;
    arm_intr(exp, n);
    tick();
`else
    src_irq = src_irq | bits;
    arm_intr(exp, n);
    tick();
`endif
  endtask

  // Acknowledge the outstanding request, then read back VEC.
  // The drop argument names the sources that withdraw once they are serviced.
  task automatic handshake(input logic [DW-1:0] exp_vec, input logic [NUM_SRC-1:0] drop,
                           input string n);
    int_ack = 1'b1;
    arm_intr(1'b0, {n, "_intr_low"});
    tick();
    src_irq = src_irq & ~drop;
    int_ack = 1'b0;
    tick();
    io_read(A_VEC, exp_vec, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sys_rst = 1'b0; src_irq = '0; io_cs = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
    io_addr = '0; io_din = '0; int_ack = 1'b0;
    repeat (3) tick();
    sys_rst = 1'b1;
    tick();

    // Reset state
    check("rst_ie", {31'b0, ie}, 32'd0);
    check("rst_intr", {31'b0, intr}, 32'd0);
    io_read(A_PEND, 32'h0, "rst_pend");
    io_read(A_MASK, 32'h0, "rst_mask");
    io_read(A_VEC,  32'd8, "rst_vec");
    io_read(A_CTRL, 32'h0, "rst_ctrl");

    // Unused bits read zero; CTRL exposes only bit 0
    io_write(A_MASK, 32'hFFFF_FFFF);
    io_write(A_CTRL, 32'hFFFF_FFFF);
    io_read(A_MASK, 32'h0000_00FF, "mask_unused_bits");
    io_read(A_CTRL, 32'h1, "ctrl_bit0_only");
    check("ie_mirror", {31'b0, ie}, 32'd1);

    // T1: reset while a request is outstanding
    raise_src(8'h01, 1'b1, "t1_req");
    sys_rst = 1'b0;
    #1;
    check("t1_intr_async", {31'b0, intr}, 32'd0);
    check("t1_ie_async", {31'b0, ie}, 32'd0);
    check("t1_state", {30'b0, dbg_state}, 32'd0);
    src_irq = '0;
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    io_read(A_PEND, 32'h0, "t1_pend");
    io_read(A_MASK, 32'h0, "t1_mask");
    io_read(A_VEC,  32'd8, "t1_vec");

    // T2: fixed priority between sources 5 and 2
    io_write(A_MASK, 32'hFF);
    io_write(A_CTRL, 32'h1);
    raise_src(8'h24, 1'b1, "t2_req");
    io_read(A_PEND, 32'h24, "t2_pend_both");
    handshake(32'd2, 8'h04, "t2_vec_first");
    io_read(A_PEND, 32'h20, "t2_pend_left");
    arm_intr(1'b1, "t2_rereq");
    tick();
    handshake(32'd5, 8'h20, "t2_vec_second");
    io_read(A_PEND, 32'h0, "t2_pend_empty");
    arm_intr(1'b0, "t2_idle");
    tick();

    // T3: masked source stays pending, then unmasking raises intr
    io_write(A_MASK, 32'h01);
    raise_src(8'h08, 1'b0, "t3_masked");
    io_read(A_PEND, 32'h08, "t3_pend");
    io_write(A_MASK, 32'h08);
    arm_intr(1'b1, "t3_unmask");
    tick();
    handshake(32'd3, 8'h08, "t3_vec");
    io_read(A_PEND, 32'h0, "t3_pend_clr");

    // T4: request vanishes before ack -> spurious vector, no retraction
    io_write(A_MASK, 32'h01);
    raise_src(8'h01, 1'b1, "t4_req");
    src_irq = src_irq & ~8'h01;
    io_write(A_PEND, 32'h01);
    arm_intr(1'b1, "t4_no_retract");
    tick();
    handshake(32'd8, 8'h00, "t4_vec_spurious");
    io_read(A_PEND, 32'h0, "t4_pend");

    // T4b: mask dropped while in REQ -> intr held, spurious vector at ack
    raise_src(8'h01, 1'b1, "t4b_req");
    io_write(A_MASK, 32'h0);
    arm_intr(1'b1, "t4b_hold");
    tick();
    handshake(32'd8, 8'h01, "t4b_vec");
`ifdef INTC_EDGE_EN
    io_read(A_PEND, 32'h01, "t4b_pend_kept");
`else
    io_read(A_PEND, 32'h00, "t4b_pend_level");
`endif
    io_write(A_PEND, 32'h01);
    io_read(A_PEND, 32'h0, "t4b_pend_clr");

    // T5: source set versus PEND write-1-to-clear in the same cycle
`ifdef INTC_EDGE_EN
    src_irq = 8'h10;
    io_write(A_PEND, 32'h10);
    src_irq = '0;
    io_read(A_PEND, 32'h10, "t5_set_wins");
    io_write(A_PEND, 32'h10);
    io_read(A_PEND, 32'h0, "t5_w1c");
`else
    src_irq = 8'h10;
    io_write(A_PEND, 32'hFF);
    io_read(A_PEND, 32'h10, "t5_w1c_ignored");
    src_irq = '0;
    io_read(A_PEND, 32'h0, "t5_follow_src");
`endif

    // T6: held source re-requests in level mode; an edge is serviced once
    io_write(A_MASK, 32'h02);
    raise_src(8'h02, 1'b1, "t6_req");
`ifdef INTC_EDGE_EN
    handshake(32'd1, 8'h00, "t6_vec");
    arm_intr(1'b0, "t6_single");
    tick();
`else
    handshake(32'd1, 8'h00, "t6_vec_a");
    arm_intr(1'b1, "t6_rereq");
    tick();
    handshake(32'd1, 8'h02, "t6_vec_b");
    arm_intr(1'b0, "t6_quiet");
    tick();
    arm_intr(1'b0, "t6_quiet2");
    tick();
`endif

    // Drain and report
    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size() + intr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
